// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi care-action front end:
// action codes, scheduler states, default timing and the round-robin pick.
package tamagotchi_pkg;

    localparam logic [2:0] ACT_NONE    = 3'd0;
    localparam logic [2:0] ACT_REGAR   = 3'd1;
    localparam logic [2:0] ACT_ABONAR  = 3'd2;
    localparam logic [2:0] ACT_PODAR   = 3'd3;
    localparam logic [2:0] ACT_REPOSAR = 3'd4;
    localparam logic [2:0] ACT_TEST    = 3'd5;

    localparam int DEB_CYCLES_DEF      = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 250_000_000;
    localparam int COOLDOWN_CYCLES_DEF = 25_000_000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_COOLDOWN = 2'd2
    } sched_state_t;

    // First requester strictly after 'last', wrapping regar->abonar->podar->reposar.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] care_code(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/tamagotchi_action_scheduler_btn.sv
// One pushbutton: 2-flop synchroniser, debouncer, press edge and
// an optional hold counter that fires once per long press.
module btn_conditioner #(
    parameter int DEB_CYCLES  = 4,
    parameter int LONG_CYCLES = 100,
    parameter bit LONG_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press,
    output logic long_press
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                level   <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

    generate
        if (LONG_EN) begin : g_long
            localparam int HW = $clog2(LONG_CYCLES + 1);
            localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
            localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

            logic [HW-1:0] hold_cnt;

            // Saturating past HOLD_LAST keeps the event from repeating.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                end else if (!level) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end

            assign long_press = level && (hold_cnt == HOLD_LAST);
        end else begin : g_nolong
            assign long_press = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/tamagotchi_action_scheduler.sv
// Care-command front end: conditions six buttons, queues care requests
// and offers them one at a time over valid/ready with a cooldown.
module tamagotchi_action_scheduler
    import tamagotchi_pkg::*;
#(
    parameter int DEB_CYCLES      = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       botonregar,
    input  logic       botonabonar,
    input  logic       botonpodar,
    input  logic       botonreposar,
    input  logic       botontest,
    input  logic       botonreset,
    input  logic       act_ready,
    output logic       act_valid,
    output logic [2:0] act_code,
    output logic       mode_test,
    output logic       reset_pulse,
    output logic [3:0] pending
);

    localparam int CW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CD_LOAD =
        (COOLDOWN_CYCLES > 0) ? CW'(COOLDOWN_CYCLES - 1) : '0;

    logic [5:0] raw;
    logic [5:0] press;
    logic [5:0] long_ev;
    logic       unused_long;

    assign raw = {botonreset, botontest, botonreposar,
                  botonpodar, botonabonar, botonregar};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        btn_conditioner #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_EN     (i >= 4)
        ) u_btn (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (raw[i]),
            .press      (press[i]),
            .long_press (long_ev[i])
        );
    end

    assign unused_long = |long_ev[3:0];

    sched_state_t  state;
    sched_state_t  state_n;
    logic          valid_n;
    logic [2:0]    code_n;
    logic          mode_n;
    logic          pulse_n;
    logic [3:0]    pend_n;
    logic          test_req;
    logic          treq_n;
    logic [1:0]    last_grant;
    logic [1:0]    last_n;
    logic [CW-1:0] cd_cnt;
    logic [CW-1:0] cd_n;
    logic [1:0]    pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            act_valid   <= 1'b0;
            act_code    <= ACT_NONE;
            mode_test   <= 1'b0;
            reset_pulse <= 1'b0;
            pending     <= '0;
            test_req    <= 1'b0;
            last_grant  <= 2'd3;
            cd_cnt      <= '0;
        end else begin
            state       <= state_n;
            act_valid   <= valid_n;
            act_code    <= code_n;
            mode_test   <= mode_n;
            reset_pulse <= pulse_n;
            pending     <= pend_n;
            test_req    <= treq_n;
            last_grant  <= last_n;
            cd_cnt      <= cd_n;
        end
    end

    always_comb begin
        state_n = state;
        valid_n = act_valid;
        code_n  = act_code;
        mode_n  = mode_test;
        pulse_n = 1'b0;
        pend_n  = pending;
        treq_n  = test_req;
        last_n  = last_grant;
        cd_n    = cd_cnt;
        pick    = rr_pick(pending, last_grant);

        unique case (state)
            ST_IDLE: begin
                if (test_req) begin
                    treq_n  = 1'b0;
                    code_n  = ACT_TEST;
                    valid_n = 1'b1;
                    state_n = ST_ISSUE;
                end else if (|pending) begin
                    pend_n[pick] = 1'b0;
                    last_n       = pick;
                    code_n       = care_code(pick);
                    valid_n      = 1'b1;
                    state_n      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (act_ready) begin
                    valid_n = 1'b0;
                    code_n  = ACT_NONE;
                    if (COOLDOWN_CYCLES == 0) begin
                        state_n = ST_IDLE;
                    end else begin
                        cd_n    = CD_LOAD;
                        state_n = ST_COOLDOWN;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    cd_n = cd_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A press landing on the bit just granted re-arms it.
        if (!mode_test) begin
            pend_n = pend_n | press[3:0];
        end else if (press[4]) begin
            treq_n = 1'b1;
        end

        if (long_ev[4]) begin
            mode_n = 1'b1;
            pend_n = '0;
        end

        if (long_ev[5]) begin
            mode_n  = 1'b0;
            pend_n  = '0;
            pulse_n = 1'b1;
            treq_n  = 1'b0;
            state_n = ST_IDLE;
            valid_n = 1'b0;
            code_n  = ACT_NONE;
            cd_n    = '0;
        end
    end

endmodule

// File: tb/tb_tamagotchi_action_scheduler.sv
// Bench for tamagotchi_action_scheduler: round tables, randomized rounds
// against a round-robin model, and hand-written corner sequences.
module tb_tamagotchi_action_scheduler;
    import tamagotchi_pkg::*;

    localparam int DEB  = 4;
    localparam int LONG = 100;
    localparam int COOL = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btn = '0;
    logic       act_ready = 1'b0;
    logic       act_valid;
    logic [2:0] act_code;
    logic       mode_test;
    logic       reset_pulse;
    logic [3:0] pending;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tamagotchi_action_scheduler #(
        .DEB_CYCLES      (DEB),
        .LONG_CYCLES     (LONG),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .botonregar   (btn[0]),
        .botonabonar  (btn[1]),
        .botonpodar   (btn[2]),
        .botonreposar (btn[3]),
        .botontest    (btn[4]),
        .botonreset   (btn[5]),
        .act_ready    (act_ready),
        .act_valid    (act_valid),
        .act_code     (act_code),
        .mode_test    (mode_test),
        .reset_pulse  (reset_pulse),
        .pending      (pending)
    );

    task automatic chk_eq(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Offer monitor, sampled 1 ns after each falling edge.
    int         cyc = 0;
    int         last_acc = 0;
    int         last_gap = 0;
    logic       pv = 1'b0;
    logic       pacc = 1'b0;
    logic [2:0] pc = '0;
    logic [2:0] acc_q[$];

    always @(negedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            if (pv && !pacc && !btn[5]) begin
                chk_eq("hold_valid", act_valid, 1);
                chk_eq("hold_code", act_code, pc);
            end
            if (!act_valid) chk_eq("idle_code", act_code, ACT_NONE);
            if (act_valid && !pv) last_gap = cyc - last_acc;
            if (act_valid && act_ready) begin
                acc_q.push_back(act_code);
                last_acc = cyc;
            end
        end
        pv   = act_valid && rst_n;
        pc   = act_code;
        pacc = act_valid && act_ready;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic [5:0] m, input int hold, input int rel);
        @(negedge clk);
        btn = btn | m;
        ticks(hold);
        btn = btn & ~m;
        ticks(rel);
    endtask

    task automatic wait_valid(input string name, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (act_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk_eq({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn = '0;
        act_ready = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(2);
    endtask

    // Press all masked care buttons together, then drain the offers.
    // Back-to-back offers: valid low for COOL cooldown cycles plus one grant cycle.
    task automatic run_round(input string tag, input logic [3:0] mask,
                             input int delay, input int n,
                             input logic [11:0] codes);
        bit ok;
        @(negedge clk);
        btn[3:0] = mask;
        for (int k = 0; k < n; k++) begin
            wait_valid({tag, "_wait"}, 300, ok);
            if (!ok) break;
            #2;
            chk_eq({tag, "_code"}, act_code, codes[3*k +: 3]);
            if (k > 0) chk_eq({tag, "_gap"}, last_gap, COOL + 2);
            ticks(delay);
            @(negedge clk);
            act_ready = 1'b1;
            @(negedge clk);
            act_ready = 1'b0;
        end
        btn[3:0] = '0;
        ticks(20);
        chk_eq({tag, "_pend"}, pending, 0);
        chk_eq({tag, "_valid"}, act_valid, 0);
    endtask

    typedef struct {
        logic [3:0]  mask;
        int          delay;
        int          n;
        logic [11:0] codes;
    } round_t;

    initial begin
        round_t     tbl[5];
        bit         ok;
        int         model_last;
        int         pulses;

        tbl[0] = '{4'b1101, 0, 3, {3'd0, 3'd4, 3'd3, 3'd1}};
        tbl[1] = '{4'b0011, 3, 2, {3'd0, 3'd0, 3'd2, 3'd1}};
        tbl[2] = '{4'b1111, 1, 4, {3'd2, 3'd1, 3'd4, 3'd3}};
        tbl[3] = '{4'b0101, 5, 2, {3'd0, 3'd0, 3'd1, 3'd3}};
        tbl[4] = '{4'b0010, 2, 1, {3'd0, 3'd0, 3'd0, 3'd2}};

        ticks(3);
        chk_eq("rst_valid", act_valid, 0);
        chk_eq("rst_code", act_code, ACT_NONE);
        chk_eq("rst_mode", mode_test, 0);
        chk_eq("rst_pulse", reset_pulse, 0);
        chk_eq("rst_pend", pending, 0);
        rst_n = 1'b1;
        ticks(2);

        // Bouncing regar, then a clean hold: exactly one regar offer.
        act_ready = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            ticks(2);
        end
        btn[0] = 1'b1;
        ticks(30);
        btn[0] = 1'b0;
        ticks(30);
        chk_eq("bounce_count", acc_q.size(), 1);
        chk_eq("bounce_code", (acc_q.size() > 0) ? int'(acc_q[0]) : 0, ACT_REGAR);
        btn[0] = 1'b1;
        ticks(3);
        btn[0] = 1'b0;
        ticks(30);
        chk_eq("glitch_count", acc_q.size(), 1);
        act_ready = 1'b0;

        do_reset();
        for (int r = 0; r < 5; r++) begin
            run_round($sformatf("tbl%0d", r), tbl[r].mask, tbl[r].delay,
                      tbl[r].n, tbl[r].codes);
        end

        model_last = 1;
        for (int r = 0; r < 10; r++) begin
            logic [3:0]  m;
            logic [11:0] c;
            int          n;
            int          idx;
            int          start;
            m = 4'($urandom_range(1, 15));
            c = '0;
            n = 0;
            start = model_last;
            for (int i = 1; i <= 4; i++) begin
                idx = (start + i) % 4;
                if (m[idx]) begin
                    c[3*n +: 3] = 3'(idx + 1);
                    n++;
                    model_last = idx;
                end
            end
            run_round($sformatf("rnd%0d", r), m, int'($urandom_range(0, 4)), n, c);
        end

        // Handshake: abonar offer held 50 cycles, two re-presses queue once.
        acc_q.delete();
        @(negedge clk);
        btn[1] = 1'b1;
        wait_valid("hs_wait", 100, ok);
        chk_eq("hs_code", act_code, ACT_ABONAR);
        btn[1] = 1'b0;
        ticks(12);
        btn[1] = 1'b1;
        ticks(8);
        btn[1] = 1'b0;
        ticks(10);
        btn[1] = 1'b1;
        ticks(8);
        btn[1] = 1'b0;
        ticks(12);
        chk_eq("hs_still_valid", act_valid, 1);
        chk_eq("hs_still_code", act_code, ACT_ABONAR);
        chk_eq("hs_pend", pending, 4'b0010);
        act_ready = 1'b1;
        @(negedge clk);
        #2;
        chk_eq("hs_first_accept", acc_q.size(), 1);
        ticks(40);
        act_ready = 1'b0;
        chk_eq("hs_total", acc_q.size(), 2);
        chk_eq("hs_second", (acc_q.size() > 1) ? int'(acc_q[1]) : 0, ACT_ABONAR);
        chk_eq("hs_pend_end", pending, 0);

        // Long reset while regar is being offered.
        @(negedge clk);
        btn[0] = 1'b1;
        wait_valid("ro_wait", 100, ok);
        chk_eq("ro_code", act_code, ACT_REGAR);
        btn[0] = 1'b0;
        ticks(12);
        press_btn(6'b000010, 10, 4);
        chk_eq("ro_pend", pending, 4'b0010);
        pulses = 0;
        btn[5] = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (reset_pulse) pulses++;
        end
        btn[5] = 1'b0;
        chk_eq("ro_pulses", pulses, 1);
        chk_eq("ro_valid", act_valid, 0);
        chk_eq("ro_pend_clr", pending, 0);
        chk_eq("ro_mode", mode_test, 0);
        ticks(30);
        chk_eq("ro_no_reoffer", act_valid, 0);

        // Test mode entry, test step, care press ignored.
        act_ready = 1'b1;
        acc_q.delete();
        @(negedge clk);
        btn[4] = 1'b1;
        ticks(130);
        btn[4] = 1'b0;
        ticks(20);
        chk_eq("tm_mode", mode_test, 1);
        chk_eq("tm_no_step", acc_q.size(), 0);
        press_btn(6'b010000, 10, 30);
        chk_eq("tm_step_count", acc_q.size(), 1);
        chk_eq("tm_step_code", (acc_q.size() > 0) ? int'(acc_q[0]) : 0, ACT_TEST);
        press_btn(6'b000001, 10, 30);
        chk_eq("tm_care_pend", pending, 0);
        chk_eq("tm_care_count", acc_q.size(), 1);

        // Asynchronous reset in the cooldown after a test step.
        @(negedge clk);
        btn[4] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk_eq("cd_step_timeout", 0, 1);
        btn[4] = 1'b0;
        ticks(2);
        chk_eq("cd_mode_before", mode_test, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("cd_rst_valid", act_valid, 0);
        chk_eq("cd_rst_code", act_code, ACT_NONE);
        chk_eq("cd_rst_mode", mode_test, 0);
        chk_eq("cd_rst_pulse", reset_pulse, 0);
        chk_eq("cd_rst_pend", pending, 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
